// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync header values and gearbox constants.
package pcs_pkg;

  typedef logic [1:0] sync_hdr_t;

  localparam sync_hdr_t SYNC_DATA       = 2'b10;
  localparam sync_hdr_t SYNC_CTRL       = 2'b01;
  localparam int        BLOCK_BITS      = 66;
  localparam int        GEARBOX_SEQ_MAX = 32;

endpackage

// File: rtl/gearbox_seq_cnt.sv
// Wrapping 0..SEQ_MAX gearbox sequence counter with a registered ready flag.
// Ready drops for exactly one cycle per period, the cycle the counter sits at SEQ_MAX.
module gearbox_seq_cnt #(
  parameter int SEQ_MAX = 32,
  parameter int CNT_W   = 6
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic [CNT_W-1:0] o_seq_cnt,
  output logic             o_ready
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic [CNT_W-1:0] w_cnt_next;

  // Next count value, wrapping from SEQ_MAX back to zero.
  always_comb begin
    w_cnt_next = (r_cnt == CNT_W'(SEQ_MAX)) ? '0 : r_cnt + CNT_W'(1);
  end

  // Counter and ready flag; ready is computed from the next count so it lines up with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_ready <= (w_cnt_next != CNT_W'(SEQ_MAX));
    end
  end

  assign o_seq_cnt = r_cnt;
  assign o_ready   = r_ready;

endmodule

// File: rtl/tx_gearbox_66b32b.sv
// TX gearbox: merges the sync header with two scrambled words into a 66-bit block
// and repacks the block stream into a continuous 32-bit line-word stream.
module tx_gearbox_66b32b
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2,
  parameter int SEQ_MAX    = GEARBOX_SEQ_MAX
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  output logic                  o_ready,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_err
);

  localparam int BUF_W = 128;
  localparam int OCC_W = 7;
  localparam int CNT_W = 6;

  logic [CNT_W-1:0]      w_seq_cnt;
  logic                  w_ready;

  logic                  r_phase;
  logic                  r_started;
  logic                  r_err;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [BUF_W-1:0]      r_buf;
  logic [OCC_W-1:0]      r_occ;

  logic                  w_accept;
  logic                  w_overflow;
  logic                  w_underflow;
  logic                  w_pop;
  logic [BUF_W-1:0]      w_ins;
  logic [BUF_W-1:0]      w_buf_ins;
  logic [OCC_W-1:0]      w_ins_bits;
  logic [OCC_W-1:0]      w_occ_sum;

  gearbox_seq_cnt #(
    .SEQ_MAX (SEQ_MAX),
    .CNT_W   (CNT_W)
  ) u_seq_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_seq_cnt (w_seq_cnt),
    .o_ready   (w_ready)
  );

  // Insert the new word (with header on phase 0) above the bits already buffered and decide whether a line word pops.
  always_comb begin
    w_accept   = i_data_valid & w_ready;
    w_overflow = i_data_valid & ~w_ready;
    w_ins      = '0;
    w_ins_bits = '0;
    if (w_accept) begin
      if (!r_phase) begin
        w_ins      = BUF_W'({i_data, i_hdr});
        w_ins_bits = OCC_W'(DATA_WIDTH + HDR_WIDTH);
      end else begin
        w_ins      = BUF_W'(i_data);
        w_ins_bits = OCC_W'(DATA_WIDTH);
      end
    end
    w_buf_ins   = r_buf | (w_ins << r_occ);
    w_occ_sum   = r_occ + w_ins_bits;
    w_pop       = (w_occ_sum >= OCC_W'(DATA_WIDTH));
    w_underflow = r_started & ~w_pop;
  end

  // Shift buffer, output word, block phase and sticky error state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase      <= 1'b0;
      r_started    <= 1'b0;
      r_err        <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_buf        <= '0;
      r_occ        <= '0;
    end else begin
      if (w_accept) begin
        r_phase   <= ~r_phase;
        r_started <= 1'b1;
      end
      r_err        <= r_err | w_overflow | w_underflow;
      r_data_valid <= w_pop;
      if (w_pop) begin
        r_data <= w_buf_ins[DATA_WIDTH-1:0];
        r_buf  <= w_buf_ins >> DATA_WIDTH;
        r_occ  <= w_occ_sum - OCC_W'(DATA_WIDTH);
      end else begin
        r_buf  <= w_buf_ins;
        r_occ  <= w_occ_sum;
      end
    end
  end

  a_occ_max: assert property (@(posedge i_clk) disable iff (!i_reset_n) r_occ <= OCC_W'(98));
  a_seq_range: assert property (@(posedge i_clk) disable iff (!i_reset_n) w_seq_cnt <= CNT_W'(SEQ_MAX));

  assign o_ready      = w_ready;
  assign o_data_valid = r_data_valid;
  assign o_data       = r_data;
  assign o_err        = r_err;

endmodule

// File: tb/tb_tx_gearbox_66b32b.sv
// Scoreboard bench for tx_gearbox_66b32b: a bit-queue reference packer predicts
// line words; a negedge monitor pops and compares every presented output.
`timescale 1ns/1ps
module tb_tx_gearbox_66b32b;
  import pcs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vld = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_hdr = '0;
  logic        o_ready;
  logic        o_vld;
  logic [31:0] o_data;
  logic        o_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  bit          bq[$];
  logic [31:0] exp_q[$];
  bit          m_phase = 0;
  bit          m_started = 0;
  bit          m_err = 0;
  bit          m_vld = 0;
  bit          mon_en = 0;

  always #5 clk = ~clk;

  tx_gearbox_66b32b dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data_valid (in_vld),
    .i_data       (in_data),
    .i_hdr        (in_hdr),
    .o_ready      (o_ready),
    .o_data_valid (o_vld),
    .o_data       (o_data),
    .o_err        (o_err)
  );

  // Cycles since reset release: cycle k (k>=1) is a pause when k mod 33 == 32.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic bit model_ready(int c);
    return (c >= 1) && ((c % 33) != 32);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference packer consumes accepted bits LSB-first.
  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] h);
    bit          rdy;
    bit          pend_err;
    bit          pend_vld;
    bit          was_started;
    logic [31:0] w;
    in_vld = v; in_data = d; in_hdr = h;
    rdy = model_ready(cyc);
    was_started = m_started;
    pend_err = 0;
    pend_vld = 0;
    w = '0;
    if (v && rdy) begin
      if (!m_phase) for (int i = 0; i < 2; i++) bq.push_back(h[i]);
      for (int i = 0; i < 32; i++) bq.push_back(d[i]);
      m_phase = !m_phase;
      m_started = 1;
    end else if (v) begin
      pend_err = 1;
    end
    if (bq.size() >= 32) begin
      for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
      exp_q.push_back(w);
      pend_vld = 1;
    end else if (was_started) begin
      pend_err = 1;
    end
    @(posedge clk); #1;
    m_err = m_err | pend_err;
    m_vld = pend_vld;
    in_vld = 0;
  endtask

  // Present a word on the next ready cycle, idling through any pause.
  task automatic send(input logic [31:0] d, input logic [1:0] h);
    int guard;
    guard = 0;
    while (!model_ready(cyc) && guard < 4) begin
      step(0, '0, '0);
      guard++;
    end
    step(1, d, h);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0; in_vld = 0; in_data = '0; in_hdr = '0;
    bq.delete(); exp_q.delete();
    m_phase = 0; m_started = 0; m_err = 0; m_vld = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
  endtask

  function automatic logic [1:0] rand_hdr();
    return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
  endfunction

  // Monitor: compares control outputs every cycle and pops a word whenever one is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) chk("rst_data", o_data, 32'h0);
      chk("ready", {31'b0, o_ready}, {31'b0, model_ready(cyc)});
      chk("err", {31'b0, o_err}, {31'b0, m_err});
      chk("valid", {31'b0, o_vld}, {31'b0, m_vld});
      if (o_vld) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL data: got %h but no word expected (t=%0t)", o_data, $time);
        end else begin
          chk("data", o_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    #1;
    mon_en = 1;
    do_reset(3);

    // First block: header lands in o_data[1:0] one cycle after the accept.
    step(0, '0, '0);
    step(1, 32'hAAAAAAAA, SYNC_DATA);
    chk("first_word", o_data, 32'hAAAAAAAA);
    chk("first_vld", {31'b0, o_vld}, 32'h1);
    step(1, 32'h55555555, SYNC_DATA);

    // Sixteen blocks of a counting pattern on every ready cycle.
    for (int b = 0; b < 16; b++) begin
      send(32'(2 * b), SYNC_DATA);
      send(32'(2 * b + 1), SYNC_CTRL);
    end
    chk("count_err", {31'b0, o_err}, 32'h0);

    // Continuous random traffic.
    for (int b = 0; b < 4850; b++) begin
      send($urandom, rand_hdr());
      send($urandom, rand_hdr());
    end
    chk("rand_err", {31'b0, o_err}, 32'h0);

    // Upstream idles for two cycles: output starves and the error latches.
    step(0, '0, '0);
    step(0, '0, '0);
    chk("uf_err", {31'b0, o_err}, 32'h1);
    for (int b = 0; b < 8; b++) begin
      send($urandom, rand_hdr());
      send($urandom, rand_hdr());
    end

    // Reset right after a phase-0 word; the next word restarts at phase 0.
    if (m_phase) send($urandom, rand_hdr());
    send(32'h12345678, SYNC_DATA);
    do_reset(3);
    step(0, '0, '0);
    step(1, 32'h00000000, SYNC_CTRL);
    chk("rst_first", o_data, 32'h00000001);
    step(1, 32'h00000000, SYNC_CTRL);
    for (int b = 0; b < 8; b++) begin
      send($urandom, rand_hdr());
      send($urandom, rand_hdr());
    end
    chk("rst_err", {31'b0, o_err}, 32'h0);

    // Word presented during the pause cycle is dropped and flags an error.
    guard = 0;
    while (model_ready(cyc) && guard < 40) begin
      step(1, $urandom, rand_hdr());
      guard++;
    end
    step(1, 32'hDEADBEEF, SYNC_DATA);
    chk("ovf_err", {31'b0, o_err}, 32'h1);
    for (int b = 0; b < 4; b++) begin
      send($urandom, rand_hdr());
      send($urandom, rand_hdr());
    end
    chk("ovf_sticky", {31'b0, o_err}, 32'h1);

    // Drain: everything predicted must have been presented.
    step(0, '0, '0);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("leftover", 32'(exp_q.size()), 32'h0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
